// File: rtl/armleocpu_axi_read_arbiter_pkg.sv
// Shared AXI constants, FSM encoding and beat-check helper for the AXI read arbiter.
package armleocpu_axi_read_arbiter_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // A beat is malformed when RLAST disagrees with whether it is the final beat of the burst.
   function automatic logic beat_error(input logic last, input logic [7:0] cnt, input logic [7:0] len);
      return last ? (cnt != len) : (cnt == len);
   endfunction

endpackage

// File: rtl/armleocpu_arbiter2.sv
// Two-requester winner selection. ARMLEOCPU_AXI_READ_ARBITER_ROUND_ROBIN_EN selects round-robin;
// otherwise requester 1 has fixed priority.
module armleocpu_arbiter2 (
   input  logic [1:0] req,
`ifdef ARMLEOCPU_AXI_READ_ARBITER_ROUND_ROBIN_EN
   input  logic       last_grant,
`endif
   output logic       winner
);

`ifdef ARMLEOCPU_AXI_READ_ARBITER_ROUND_ROBIN_EN
   assign winner = (req == 2'b11) ? ~last_grant : req[1];
`else
   // Requester 0 wins only when it is asking alone; winner is don't-care with no request.
   assign winner = !(req[0] && !req[1]);
`endif

endmodule

// File: rtl/armleocpu_axi_read_arbiter.sv
// Shares one AXI4 read port between fetch (port 0) and memory stage (port 1), one burst at a time.
// Optional macro ARMLEOCPU_AXI_READ_ARBITER_ROUND_ROBIN_EN enables round-robin arbitration.
module armleocpu_axi_read_arbiter
   import armleocpu_axi_read_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  s0_arvalid,
   input  logic [ADDR_WIDTH-1:0] s0_araddr,
   input  logic [7:0]            s0_arlen,
   input  logic [2:0]            s0_arprot,
   output logic                  s0_arready,
   output logic                  s0_rvalid,
   output logic [DATA_WIDTH-1:0] s0_rdata,
   output logic [1:0]            s0_rresp,
   output logic                  s0_rlast,
   input  logic                  s0_rready,

   input  logic                  s1_arvalid,
   input  logic [ADDR_WIDTH-1:0] s1_araddr,
   input  logic [7:0]            s1_arlen,
   input  logic [2:0]            s1_arprot,
   output logic                  s1_arready,
   output logic                  s1_rvalid,
   output logic [DATA_WIDTH-1:0] s1_rdata,
   output logic [1:0]            s1_rresp,
   output logic                  s1_rlast,
   input  logic                  s1_rready,

   output logic                  M_AXI_ARVALID,
   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [7:0]            M_AXI_ARLEN,
   output logic [2:0]            M_AXI_ARPROT,
   output logic [2:0]            M_AXI_ARSIZE,
   output logic [1:0]            M_AXI_ARBURST,
   input  logic                  M_AXI_ARREADY,
   input  logic                  M_AXI_RVALID,
   input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RLAST,
   output logic                  M_AXI_RREADY,

   output logic                  grant_o,
   output logic                  busy_o,
   output logic                  protocol_err_o
);

   state_t     state_q, state_d;
   logic       grant_q;
   logic [7:0] len_q;
   logic [7:0] beat_cnt_q;
   logic       protocol_err_q;
   logic       winner;
   logic       ar_valid, ar_hs;
   logic       r_ready, r_hs;
   logic       beat_err;
   logic [1:0] fwd_resp;
`ifdef ARMLEOCPU_AXI_READ_ARBITER_ROUND_ROBIN_EN
   logic       last_grant_q;
`endif

   armleocpu_arbiter2 u_arbiter2 (
      .req        ({s1_arvalid, s0_arvalid}),
`ifdef ARMLEOCPU_AXI_READ_ARBITER_ROUND_ROBIN_EN
      .last_grant (last_grant_q),
`endif
      .winner     (winner)
   );

   assign M_AXI_ARSIZE   = AXI_SIZE_4B;
   assign M_AXI_ARBURST  = AXI_BURST_INCR;
   assign grant_o        = grant_q;
   assign busy_o         = (state_q != ST_IDLE);
   assign protocol_err_o = protocol_err_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
      state_d       = state_q;
      ar_valid      = 1'b0;
      ar_hs         = 1'b0;
      r_ready       = 1'b0;
      r_hs          = 1'b0;
      beat_err      = 1'b0;
      fwd_resp      = AXI_RESP_OKAY;
      s0_arready    = 1'b0;
      s1_arready    = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_ARADDR  = '0;
      M_AXI_ARLEN   = '0;
      M_AXI_ARPROT  = '0;
      M_AXI_RREADY  = 1'b0;
      s0_rvalid     = 1'b0;
      s0_rdata      = '0;
      s0_rresp      = AXI_RESP_OKAY;
      s0_rlast      = 1'b0;
      s1_rvalid     = 1'b0;
      s1_rdata      = '0;
      s1_rresp      = AXI_RESP_OKAY;
      s1_rlast      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (s0_arvalid || s1_arvalid) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            ar_valid      = grant_q ? s1_arvalid : s0_arvalid;
            ar_hs         = ar_valid && M_AXI_ARREADY;
            M_AXI_ARVALID = ar_valid;
            M_AXI_ARADDR  = grant_q ? s1_araddr : s0_araddr;
            M_AXI_ARLEN   = len_q;
            M_AXI_ARPROT  = grant_q ? s1_arprot : s0_arprot;
            s0_arready    = !grant_q && M_AXI_ARREADY;
            s1_arready    = grant_q && M_AXI_ARREADY;
            if (ar_hs) state_d = ST_DATA;
         end
         ST_DATA: begin
            r_ready      = grant_q ? s1_rready : s0_rready;
            r_hs         = M_AXI_RVALID && r_ready;
            beat_err     = beat_error(M_AXI_RLAST, beat_cnt_q, len_q);
            fwd_resp     = beat_err ? AXI_RESP_SLVERR : M_AXI_RRESP;
            M_AXI_RREADY = r_ready;
            if (grant_q) begin
               s1_rvalid = M_AXI_RVALID;
               s1_rdata  = M_AXI_RDATA;
               s1_rresp  = fwd_resp;
               s1_rlast  = M_AXI_RLAST;
            end else begin
               s0_rvalid = M_AXI_RVALID;
               s0_rdata  = M_AXI_RDATA;
               s0_rresp  = fwd_resp;
               s0_rlast  = M_AXI_RLAST;
            end
            if (r_hs && M_AXI_RLAST) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         grant_q        <= 1'b0;
         len_q          <= '0;
         beat_cnt_q     <= '0;
         protocol_err_q <= 1'b0;
`ifdef ARMLEOCPU_AXI_READ_ARBITER_ROUND_ROBIN_EN
         last_grant_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register here samples pre-edge values.
         state_q <= state_d;
         if (state_q == ST_IDLE && (s0_arvalid || s1_arvalid)) begin
            grant_q <= winner;
            len_q   <= winner ? s1_arlen : s0_arlen;
         end
         if (ar_hs)     beat_cnt_q <= '0;
         else if (r_hs) beat_cnt_q <= beat_cnt_q + 8'd1;
         if (r_hs && beat_err) protocol_err_q <= 1'b1;
`ifdef ARMLEOCPU_AXI_READ_ARBITER_ROUND_ROBIN_EN
         if (r_hs && M_AXI_RLAST) last_grant_q <= grant_q;
`endif
      end
   end

endmodule

// File: tb/tb_armleocpu_axi_read_arbiter.sv
// Scoreboard bench for armleocpu_axi_read_arbiter; follows ARMLEOCPU_AXI_READ_ARBITER_ROUND_ROBIN_EN.
module tb_armleocpu_axi_read_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        s0_arvalid, s0_arready, s0_rvalid, s0_rlast, s0_rready;
   logic [31:0] s0_araddr, s0_rdata;
   logic [7:0]  s0_arlen;
   logic [2:0]  s0_arprot;
   logic [1:0]  s0_rresp;
   logic        s1_arvalid, s1_arready, s1_rvalid, s1_rlast, s1_rready;
   logic [31:0] s1_araddr, s1_rdata;
   logic [7:0]  s1_arlen;
   logic [2:0]  s1_arprot;
   logic [1:0]  s1_rresp;
   logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
   logic [31:0] m_araddr, m_rdata;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arprot, m_arsize;
   logic [1:0]  m_arburst, m_rresp;
   logic        grant_o, busy_o, protocol_err_o;

   typedef struct { logic port; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
   typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] prot; } ar_exp_t;

   r_exp_t  r_q[$];
   ar_exp_t ar_q[$];
   int      n_checks = 0;
   int      n_fail = 0;

   localparam logic [2:0] P0 = 3'b100;
   localparam logic [2:0] P1 = 3'b011;

   always #5 clk = ~clk;

   armleocpu_axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arprot(s0_arprot),
      .s0_arready(s0_arready), .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
      .s0_rlast(s0_rlast), .s0_rready(s0_rready),
      .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arprot(s1_arprot),
      .s1_arready(s1_arready), .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
      .s1_rlast(s1_rlast), .s1_rready(s1_rready),
      .M_AXI_ARVALID(m_arvalid), .M_AXI_ARADDR(m_araddr), .M_AXI_ARLEN(m_arlen),
      .M_AXI_ARPROT(m_arprot), .M_AXI_ARSIZE(m_arsize), .M_AXI_ARBURST(m_arburst),
      .M_AXI_ARREADY(m_arready), .M_AXI_RVALID(m_rvalid), .M_AXI_RDATA(m_rdata),
      .M_AXI_RRESP(m_rresp), .M_AXI_RLAST(m_rlast), .M_AXI_RREADY(m_rready),
      .grant_o(grant_o), .busy_o(busy_o), .protocol_err_o(protocol_err_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Requester: hold the request until accepted, then drop it after that edge.
   task automatic issue(input logic port, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] prot);
      int   n = 0;
      logic hs = 1'b0;
      if (port) begin
         s1_araddr = addr; s1_arlen = len; s1_arprot = prot; s1_arvalid = 1'b1;
      end else begin
         s0_araddr = addr; s0_arlen = len; s0_arprot = prot; s0_arvalid = 1'b1;
      end
      while (!hs && n < 200) begin
         @(negedge clk);
         n++;
         hs = port ? s1_arready : s0_arready;
      end
      check("ar_accept", hs, 1'b1);
      @(posedge clk); #1;
      if (port) s1_arvalid = 1'b0;
      else      s0_arvalid = 1'b0;
   endtask

   // Slave: present one R beat until accepted; the expected forwarded beat goes to the scoreboard.
   task automatic send_beat(input logic port, input logic [31:0] data, input logic [1:0] resp,
                            input logic last, input logic [1:0] exp_resp);
      int n = 0;
      r_q.push_back('{port: port, data: data, resp: exp_resp, last: last});
      m_rvalid = 1'b1; m_rdata = data; m_rresp = resp; m_rlast = last;
      do begin
         @(negedge clk);
         n++;
      end while (!m_rready && n < 200);
      check("r_accept", m_rready, 1'b1);
      check("r_grant", grant_o, port);
      check("r_other_rvalid", port ? s0_rvalid : s1_rvalid, 1'b0);
      @(posedge clk); #1;
      m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
   endtask

   always @(negedge clk) begin : mon_ar
      ar_exp_t e;
      if (rst_n && m_arvalid && m_arready) begin
         check("ar_expected", ar_q.size() != 0, 1'b1);
         if (ar_q.size() != 0) begin
            e = ar_q.pop_front();
            check("ar_addr", m_araddr, e.addr);
            check("ar_len", m_arlen, e.len);
            check("ar_prot", m_arprot, e.prot);
            check("ar_size", m_arsize, 3'b010);
            check("ar_burst", m_arburst, 2'b01);
         end
      end
   end

   task automatic compare_beat(input logic port, input logic [31:0] data, input logic [1:0] resp,
                               input logic last);
      r_exp_t e;
      check("r_expected", r_q.size() != 0, 1'b1);
      if (r_q.size() != 0) begin
         e = r_q.pop_front();
         check("r_port", port, e.port);
         check("r_data", data, e.data);
         check("r_resp", resp, e.resp);
         check("r_last", last, e.last);
      end
   endtask

   always @(negedge clk) begin
      if (s0_rvalid && s0_rready) compare_beat(1'b0, s0_rdata, s0_rresp, s0_rlast);
      if (s1_rvalid && s1_rready) compare_beat(1'b1, s1_rdata, s1_rresp, s1_rlast);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      s0_arvalid = 0; s0_araddr = '0; s0_arlen = '0; s0_arprot = '0; s0_rready = 1;
      s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0; s1_arprot = '0; s1_rready = 1;
      m_arready = 1; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0;

      #12;
      check("rst_busy", busy_o, 1'b0);
      check("rst_grant", grant_o, 1'b0);
      check("rst_perr", protocol_err_o, 1'b0);
      check("rst_arvalid", m_arvalid, 1'b0);
      check("rst_rready", m_rready, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      // 1: fetch alone, 4-beat burst
      @(posedge clk); #1;
      ar_q.push_back('{addr: 32'h1000, len: 8'd3, prot: P0});
      fork
         issue(1'b0, 32'h1000, 8'd3, P0);
         begin
            @(negedge clk);
            check("t1_arvalid_c0", m_arvalid, 1'b0);
            check("t1_s0_arready_idle", s0_arready, 1'b0);
            @(negedge clk);
            check("t1_arvalid_c1", m_arvalid, 1'b1);
            check("t1_busy", busy_o, 1'b1);
            check("t1_s1_arready", s1_arready, 1'b0);
         end
         begin
            for (int i = 0; i < 4; i++)
               send_beat(1'b0, 32'hA000_0000 + i, 2'b00, (i == 3), 2'b00);
         end
      join
      check("t1_busy_end", busy_o, 1'b0);

      // 2: contention (A), memory stage alone (B), contention again (C)
      ar_q.push_back('{addr: 32'h2000, len: 8'd0, prot: P1});
      ar_q.push_back('{addr: 32'h1100, len: 8'd0, prot: P0});
      fork
         issue(1'b0, 32'h1100, 8'd0, P0);
         issue(1'b1, 32'h2000, 8'd0, P1);
         begin
            send_beat(1'b1, 32'hB000_0001, 2'b00, 1'b1, 2'b00);
            check("t2_dead_cycle", busy_o, 1'b0);
            send_beat(1'b0, 32'hB000_0002, 2'b00, 1'b1, 2'b00);
         end
      join
      ar_q.push_back('{addr: 32'h2100, len: 8'd0, prot: P1});
      fork
         issue(1'b1, 32'h2100, 8'd0, P1);
         send_beat(1'b1, 32'hB000_0003, 2'b00, 1'b1, 2'b00);
      join
`ifdef ARMLEOCPU_AXI_READ_ARBITER_ROUND_ROBIN_EN
      ar_q.push_back('{addr: 32'h1200, len: 8'd0, prot: P0});
      ar_q.push_back('{addr: 32'h2200, len: 8'd0, prot: P1});
`else
      ar_q.push_back('{addr: 32'h2200, len: 8'd0, prot: P1});
      ar_q.push_back('{addr: 32'h1200, len: 8'd0, prot: P0});
`endif
      fork
         issue(1'b0, 32'h1200, 8'd0, P0);
         issue(1'b1, 32'h2200, 8'd0, P1);
         begin
`ifdef ARMLEOCPU_AXI_READ_ARBITER_ROUND_ROBIN_EN
            send_beat(1'b0, 32'hB000_0004, 2'b00, 1'b1, 2'b00);
            send_beat(1'b1, 32'hB000_0005, 2'b00, 1'b1, 2'b00);
`else
            send_beat(1'b1, 32'hB000_0005, 2'b00, 1'b1, 2'b00);
            send_beat(1'b0, 32'hB000_0004, 2'b00, 1'b1, 2'b00);
`endif
         end
      join

      // 3: fetch stalls R for three cycles
      ar_q.push_back('{addr: 32'h3000, len: 8'd1, prot: P0});
      issue(1'b0, 32'h3000, 8'd1, P0);
      s0_rready = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'hC000_0000; m_rresp = 2'b00; m_rlast = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_rready_low", m_rready, 1'b0);
         check("t3_s0_rvalid", s0_rvalid, 1'b1);
         check("t3_s1_rvalid", s1_rvalid, 1'b0);
      end
      @(posedge clk); #1;
      s0_rready = 1'b1;
      send_beat(1'b0, 32'hC000_0000, 2'b00, 1'b0, 2'b00);
      send_beat(1'b0, 32'hC000_0001, 2'b01, 1'b1, 2'b01);

      // 4: early RLAST
      check("t4_perr_pre", protocol_err_o, 1'b0);
      ar_q.push_back('{addr: 32'h4000, len: 8'd1, prot: P0});
      issue(1'b0, 32'h4000, 8'd1, P0);
      send_beat(1'b0, 32'hD000_0000, 2'b00, 1'b1, 2'b10);
      check("t4_perr", protocol_err_o, 1'b1);
      check("t4_idle", busy_o, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("t4_perr_sticky", protocol_err_o, 1'b1);

      // 5: missing RLAST on the final beat
      ar_q.push_back('{addr: 32'h5000, len: 8'd0, prot: P0});
      issue(1'b0, 32'h5000, 8'd0, P0);
      send_beat(1'b0, 32'hE000_0000, 2'b00, 1'b0, 2'b10);
      check("t5_still_busy", busy_o, 1'b1);
      send_beat(1'b0, 32'hE000_0001, 2'b00, 1'b1, 2'b10);
      check("t5_idle", busy_o, 1'b0);
      check("t5_perr", protocol_err_o, 1'b1);

      // 6: reset during DATA, then a normal fetch
      ar_q.push_back('{addr: 32'h6000, len: 8'd2, prot: P1});
      issue(1'b1, 32'h6000, 8'd2, P1);
      s1_rready = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00; m_rlast = 1'b0;
      @(negedge clk);
      check("t6_pre_rvalid", s1_rvalid, 1'b1);
      check("t6_pre_rdata", s1_rdata, 32'hDEAD_BEEF);
      check("t6_pre_grant", grant_o, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_busy", busy_o, 1'b0);
      check("t6_grant", grant_o, 1'b0);
      check("t6_perr", protocol_err_o, 1'b0);
      check("t6_s1_rvalid", s1_rvalid, 1'b0);
      check("t6_s1_rdata", s1_rdata, 32'h0);
      check("t6_rready", m_rready, 1'b0);
      check("t6_arvalid", m_arvalid, 1'b0);
      check("t6_arready", {s1_arready, s0_arready}, 2'b00);
      m_rvalid = 1'b0; m_rdata = '0;
      s1_rready = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      ar_q.push_back('{addr: 32'h6100, len: 8'd0, prot: P0});
      fork
         issue(1'b0, 32'h6100, 8'd0, P0);
         send_beat(1'b0, 32'hF000_0000, 2'b00, 1'b1, 2'b00);
      join
      check("t6_after_idle", busy_o, 1'b0);
      check("t6_after_perr", protocol_err_o, 1'b0);

      repeat (2) @(negedge clk);
      check("sb_r_empty", r_q.size(), 0);
      check("sb_ar_empty", ar_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
